// File: rtl/tx_capture_pkg.sv
// Shared FSM encoding and sizing helpers for the tx_interface capture sink.
package tx_capture_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        WAIT   = 3'd2,
        REQ    = 3'd3,
        SETTLE = 3'd4
    } state_t;

    localparam int BIT_CNT_MAX = 15;

    // Captured entry is {last_bit_in_byte, data}.
    function automatic int entry_width(input int data_width);
        return data_width + 1;
    endfunction

    // The delay counter is loaded with REQ_DELAY-1 in WAIT and SETTLE_DELAY in SETTLE.
    function automatic int delay_cnt_width(input int req_delay, input int settle_delay);
        int longest;
        longest = (req_delay - 1 > settle_delay) ? req_delay - 1 : settle_delay;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous show-ahead FIFO; rd_data is the head entry whenever empty is low.
// A write while full is dropped unless a read frees the slot in the same cycle.
module capture_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/tx_frame_capture.sv
// Paced tx_interface consumer: samples a transfer, pulses req REQ_DELAY+1 cycles later, captures into a FIFO.
// Samples repeat every REQ_DELAY+SETTLE_DELAY+3 cycles; protocol faults raise sticky err_* flags.
module tx_frame_capture
    import tx_capture_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BY_BYTE      = 1,
    parameter int DEPTH        = 64,
    parameter int REQ_DELAY    = 4,
    parameter int SETTLE_DELAY = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [2:0]            data_bits,
    input  logic                  last_bit_in_byte,
    output logic                  req,
    input  logic                  rd_en,
    output logic [DATA_WIDTH:0]   rd_data,
    output logic                  rd_empty,
    output logic [3:0]            bits_in_first_byte,
    output logic                  frame_done,
    output logic                  err_overflow,
    output logic                  err_partial,
    output logic                  err_merge,
    input  logic                  err_clear
);

    localparam int ENTRY_W = entry_width(DATA_WIDTH);
    localparam int DLY_W   = delay_cnt_width(REQ_DELAY, SETTLE_DELAY);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } capture_entry_t;

    state_t         state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic           first_tfer_q, first_tfer_d;
    logic           first_byte_q, first_byte_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]     bifb_q, bifb_d;
    logic           req_q, req_d;
    logic           done_q, done_d;
    logic           ovf_q, part_q, merge_q;
    logic           set_ovf, set_part, set_merge;
    logic           push;
    logic           fifo_full;
    logic           fifo_empty;
    capture_entry_t wr_entry;

    assign wr_entry.last = last_bit_in_byte;
    assign wr_entry.data = data;
    assign set_ovf       = push & fifo_full & ~rd_en;

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        first_tfer_d = first_tfer_q;
        first_byte_d = first_byte_q;
        bit_cnt_d    = bit_cnt_q;
        bifb_d       = bifb_q;
        done_d       = 1'b0;
        push         = 1'b0;
        set_part     = 1'b0;
        set_merge    = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d      = SAMPLE;
                    first_tfer_d = 1'b1;
                    first_byte_d = 1'b1;
                    bit_cnt_d    = '0;
                end
            end
            SAMPLE: begin
                push         = 1'b1;
                set_merge    = first_tfer_q & ~fifo_empty;
                first_tfer_d = 1'b0;
                if (BY_BYTE != 0) begin
                    if (first_tfer_q) begin
                        bifb_d = {1'b0, data_bits};
                    end else begin
                        set_part = (data_bits != 3'd0);
                    end
                end else if (first_byte_q) begin
                    // Bit mode: count bits up to and including the first byte end.
                    if (bit_cnt_q != 4'(BIT_CNT_MAX)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    bifb_d = bit_cnt_d;
                    if (last_bit_in_byte) begin
                        first_byte_d = 1'b0;
                    end
                end
                state_d = WAIT;
                dly_d   = DLY_W'(REQ_DELAY - 1);
            end
            WAIT: begin
                if (dly_q == '0) begin
                    state_d = REQ;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            REQ: begin
                state_d = SETTLE;
                dly_d   = DLY_W'(SETTLE_DELAY);
            end
            SETTLE: begin
                if (dly_q == '0) begin
                    if (data_valid) begin
                        state_d = SAMPLE;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dly_q        <= '0;
            first_tfer_q <= 1'b0;
            first_byte_q <= 1'b0;
            bit_cnt_q    <= '0;
            bifb_q       <= '0;
            req_q        <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            part_q       <= 1'b0;
            merge_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            first_tfer_q <= first_tfer_d;
            first_byte_q <= first_byte_d;
            bit_cnt_q    <= bit_cnt_d;
            bifb_q       <= bifb_d;
            req_q        <= req_d;
            done_q       <= done_d;
            // A same-cycle set outranks err_clear.
            ovf_q        <= set_ovf   | (ovf_q   & ~err_clear);
            part_q       <= set_part  | (part_q  & ~err_clear);
            merge_q      <= set_merge | (merge_q & ~err_clear);
        end
    end

    capture_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push),
        .wr_data(wr_entry),
        .rd_en  (rd_en),
        .rd_data(rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign req                = req_q;
    assign rd_empty           = fifo_empty;
    assign bits_in_first_byte = bifb_q;
    assign frame_done         = done_q;
    assign err_overflow       = ovf_q;
    assign err_partial        = part_q;
    assign err_merge          = merge_q;

endmodule

// File: tb/tb_tx_frame_capture.sv
// Bench for tx_frame_capture: three instances (byte/64, bit/16, byte/4) share one encoder stimulus.
module tb_tx_frame_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_valid;
    logic [7:0] data;
    logic [2:0] data_bits;
    logic       last_bit;
    logic       rd_en;
    logic       err_clear;

    logic       req_a, rd_empty_a, frame_done_a, ovf_a, part_a, merge_a;
    logic [8:0] rd_data_a;
    logic [3:0] bifb_a;
    logic       req_b, rd_empty_b, frame_done_b, ovf_b, part_b, merge_b;
    logic [1:0] rd_data_b;
    logic [3:0] bifb_b;
    logic       req_c, rd_empty_c, frame_done_c, ovf_c, part_c, merge_c;
    logic [8:0] rd_data_c;
    logic [3:0] bifb_c;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [7:0] fr_data [16];
    logic [2:0] fr_bits [16];
    logic       fr_last [16];
    int         req_t [16];

    logic [8:0] exp_a[$], exp_c[$], obs_a[$], obs_c[$];
    logic [1:0] exp_b[$], obs_b[$];
    bit         m_ovf_a, m_ovf_c, m_merge_a, m_merge_c, m_part;
    logic [3:0] m_bifb;

    tx_frame_capture u_a (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .data_bits(data_bits),
        .last_bit_in_byte(last_bit), .req(req_a), .rd_en(rd_en), .rd_data(rd_data_a),
        .rd_empty(rd_empty_a), .bits_in_first_byte(bifb_a), .frame_done(frame_done_a),
        .err_overflow(ovf_a), .err_partial(part_a), .err_merge(merge_a), .err_clear(err_clear));

    tx_frame_capture #(.DATA_WIDTH(1), .BY_BYTE(0), .DEPTH(16)) u_b (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data[0:0]), .data_bits(data_bits),
        .last_bit_in_byte(last_bit), .req(req_b), .rd_en(rd_en), .rd_data(rd_data_b),
        .rd_empty(rd_empty_b), .bits_in_first_byte(bifb_b), .frame_done(frame_done_b),
        .err_overflow(ovf_b), .err_partial(part_b), .err_merge(merge_b), .err_clear(err_clear));

    tx_frame_capture #(.DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .data_bits(data_bits),
        .last_bit_in_byte(last_bit), .req(req_c), .rd_en(rd_en), .rd_data(rd_data_c),
        .rd_empty(rd_empty_c), .bits_in_first_byte(bifb_c), .frame_done(frame_done_c),
        .err_overflow(ovf_c), .err_partial(part_c), .err_merge(merge_c), .err_clear(err_clear));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (frame_done_a) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_flush();
        exp_a.delete();
        exp_b.delete();
        exp_c.delete();
    endfunction

    function automatic void model_clear();
        model_flush();
        m_ovf_a = 0; m_ovf_c = 0; m_merge_a = 0; m_merge_c = 0; m_part = 0;
        m_bifb = 4'd0;
    endfunction

    // One transfer accepted by every sink: store it where room remains, note faults.
    function automatic void model_push(input int i);
        if (i == 0) begin
            if (exp_a.size() != 0) m_merge_a = 1;
            if (exp_c.size() != 0) m_merge_c = 1;
            m_bifb = {1'b0, fr_bits[0]};
        end else if (fr_bits[i] != 3'd0) begin
            m_part = 1;
        end
        if (exp_a.size() < 64) exp_a.push_back({fr_last[i], fr_data[i]}); else m_ovf_a = 1;
        if (exp_c.size() < 4) exp_c.push_back({fr_last[i], fr_data[i]}); else m_ovf_c = 1;
        if (exp_b.size() < 16) exp_b.push_back({fr_last[i], fr_data[i][0]});
    endfunction

    // Bit mode: bits up to and including the first byte end, capped at 15.
    function automatic logic [3:0] exp_bits_b(input int n);
        int c = n;
        for (int i = n - 1; i >= 0; i--) if (fr_last[i]) c = i + 1;
        return (c > 15) ? 4'd15 : 4'(c);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; data_valid = 1'b0; rd_en = 1'b0; err_clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    // Behaves like an encoder: hold each transfer until req, then present the next.
    task automatic send_frame(input int n, output bit to);
        int w;
        to = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_valid = 1'b1; data = fr_data[i]; data_bits = fr_bits[i]; last_bit = fr_last[i];
            w = 0;
            while (!req_a && w < 40) begin @(negedge clk); w++; end
            if (w >= 40) begin to = 1'b1; data_valid = 1'b0; return; end
            req_t[i] = cyc;
            model_push(i);
        end
        @(negedge clk);
        data_valid = 1'b0;
        w = 0;
        while (!frame_done_a && w < 40) begin @(negedge clk); w++; end
        if (w >= 40) to = 1'b1;
    endtask

    task automatic drain(output bit to);
        obs_a.delete(); obs_b.delete(); obs_c.delete();
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rd_empty_a && rd_empty_b && rd_empty_c) begin
                to = 1'b0;
                break;
            end
            if (!rd_empty_a) obs_a.push_back(rd_data_a);
            if (!rd_empty_b) obs_b.push_back(rd_data_b);
            if (!rd_empty_c) obs_c.push_back(rd_data_c);
            rd_en = 1'b1;
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_a !== 1'b0) $display("FAIL reset req: got %b want 0", req_a); else passed++;
        checks++; if (frame_done_a !== 1'b0) $display("FAIL reset frame_done: got %b want 0", frame_done_a); else passed++;
        checks++; if ({ovf_a, part_a, merge_a} !== 3'b000) $display("FAIL reset err: got %b want 000", {ovf_a, part_a, merge_a}); else passed++;
        checks++; if (bifb_a !== 4'd0) $display("FAIL reset bifb: got %0d want 0", bifb_a); else passed++;
        checks++; if ({rd_empty_a, rd_empty_b, rd_empty_c} !== 3'b111) $display("FAIL reset rd_empty: got %b want 111", {rd_empty_a, rd_empty_b, rd_empty_c}); else passed++;
    endtask

    task automatic test_full_bytes();
        bit to;
        int d0;
        logic [8:0] want [3];
        want[0] = 9'h0A5; want[1] = 9'h03C; want[2] = 9'h0FF;
        do_reset();
        fr_data[0] = 8'hA5; fr_data[1] = 8'h3C; fr_data[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin fr_bits[i] = 3'd0; fr_last[i] = 1'b0; end
        d0 = done_cnt;
        send_frame(3, to);
        repeat (3) @(negedge clk);
        checks++; if (to) $display("FAIL full_bytes timeout: got expired want req/frame_done"); else passed++;
        checks++; if (req_t[1] - req_t[0] != 13) $display("FAIL full_bytes req_period1: got %0d want 13", req_t[1] - req_t[0]); else passed++;
        checks++; if (req_t[2] - req_t[1] != 13) $display("FAIL full_bytes req_period2: got %0d want 13", req_t[2] - req_t[1]); else passed++;
        checks++; if (done_cnt - d0 != 1) $display("FAIL full_bytes frame_done_cycles: got %0d want 1", done_cnt - d0); else passed++;
        checks++; if ({ovf_a, part_a, merge_a} !== 3'b000) $display("FAIL full_bytes err: got %b want 000", {ovf_a, part_a, merge_a}); else passed++;
        drain(to);
        checks++; if (obs_a.size() != 3) $display("FAIL full_bytes count: got %0d want 3", obs_a.size()); else passed++;
        for (int k = 0; k < 3 && k < obs_a.size(); k++) begin
            checks++; if (obs_a[k] !== want[k]) $display("FAIL full_bytes entry%0d: got %h want %h", k, obs_a[k], want[k]); else passed++;
        end
        model_flush();
    endtask

    task automatic test_partial_first();
        bit to;
        do_reset();
        for (int i = 0; i < 3; i++) begin fr_data[i] = 8'($urandom); fr_last[i] = 1'b0; fr_bits[i] = 3'd0; end
        fr_bits[0] = 3'd3;
        send_frame(3, to);
        checks++; if (bifb_a !== 4'd3) $display("FAIL partial bifb: got %0d want 3", bifb_a); else passed++;
        checks++; if (part_a !== 1'b0) $display("FAIL partial first_ok: got %b want 0", part_a); else passed++;
        drain(to);
        model_flush();
        fr_bits[0] = 3'd0; fr_bits[1] = 3'd5;
        send_frame(3, to);
        checks++; if (to) $display("FAIL partial timeout: got expired want req/frame_done"); else passed++;
        checks++; if (part_a !== 1'b1) $display("FAIL partial err_set: got %b want 1", part_a); else passed++;
        checks++; if (bifb_a !== 4'd0) $display("FAIL partial bifb2: got %0d want 0", bifb_a); else passed++;
        drain(to);
        checks++; if (obs_a.size() != 3 || obs_a[1] !== {1'b0, fr_data[1]}) $display("FAIL partial still_captured: got %0d entries want 3"
, obs_a.size()); else passed++;
        model_flush();
        pulse_clear();
        checks++; if (part_a !== 1'b0) $display("FAIL partial err_clear: got %b want 0", part_a); else passed++;
    endtask

    task automatic test_bit_mode();
        bit to;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            fr_data[i] = 8'($urandom); fr_bits[i] = 3'd0; fr_last[i] = (i == 2 || i == 10);
        end
        fr_data[0][0] = 1'b1; fr_data[1][0] = 1'b0; fr_data[2][0] = 1'b1;
        send_frame(11, to);
        checks++; if (bifb_b !== 4'd3) $display("FAIL bit_mode bifb: got %0d want 3", bifb_b); else passed++;
        drain(to);
        checks++; if (obs_b.size() != 11) $display("FAIL bit_mode count: got %0d want 11", obs_b.size()); else passed++;
        for (int k = 0; k < 11 && k < obs_b.size(); k++) begin
            checks++;
            if (obs_b[k] !== {(k == 2 || k == 10) ? 1'b1 : 1'b0, fr_data[k][0]})
                $display("FAIL bit_mode entry%0d: got %b want %b", k, obs_b[k], {(k == 2 || k == 10) ? 1'b1 : 1'b0, fr_data[k][0]});
            else passed++;
        end
        model_flush();
    endtask

    task automatic test_overflow_merge();
        bit to;
        do_reset();
        for (int i = 0; i < 6; i++) begin fr_data[i] = 8'($urandom); fr_bits[i] = 3'd0; fr_last[i] = 1'($urandom); end
        send_frame(6, to);
        checks++; if (ovf_c !== 1'b1) $display("FAIL overflow set: got %b want 1", ovf_c); else passed++;
        checks++; if (ovf_a !== 1'b0) $display("FAIL overflow deep_fifo: got %b want 0", ovf_a); else passed++;
        checks++; if (merge_c !== 1'b0) $display("FAIL overflow no_merge_yet: got %b want 0", merge_c); else passed++;
        send_frame(1, to);
        checks++; if (merge_c !== 1'b1) $display("FAIL overflow merge: got %b want 1", merge_c); else passed++;
        drain(to);
        checks++; if (obs_c.size() != 4) $display("FAIL overflow kept: got %0d want 4", obs_c.size()); else passed++;
        for (int k = 0; k < 4 && k < obs_c.size(); k++) begin
            checks++; if (obs_c[k] !== exp_c[k]) $display("FAIL overflow entry%0d: got %h want %h", k, obs_c[k], exp_c[k]); else passed++;
        end
        model_flush();
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int w, seen;
        do_reset();
        @(negedge clk);
        data_valid = 1'b1; data = 8'h11; data_bits = 3'd0; last_bit = 1'b0;
        w = 0;
        while (!req_a && w < 40) begin @(negedge clk); w++; end
        @(negedge clk);
        data = 8'h22;
        w = 0;
        while (!req_a && w < 40) begin @(negedge clk); w++; end
        checks++; if (w >= 40) $display("FAIL rst_mid timeout: got expired want req"); else passed++;
        rst = 1'b1;
        #1;
        checks++; if ({req_a, req_b, req_c} !== 3'b000) $display("FAIL rst_mid req_drop: got %b want 000", {req_a, req_b, req_c}); else passed++;
        checks++; if (rd_empty_a !== 1'b1) $display("FAIL rst_mid flush: got %b want 1", rd_empty_a); else passed++;
        data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        seen = 0;
        repeat (20) begin @(negedge clk); if (req_a || frame_done_a) seen++; end
        checks++; if (seen != 0) $display("FAIL rst_mid idle: got %0d events want 0", seen); else passed++;
        fr_data[0] = 8'h5A; fr_data[1] = 8'hC3;
        for (int i = 0; i < 2; i++) begin fr_bits[i] = 3'd0; fr_last[i] = 1'b0; end
        send_frame(2, to);
        checks++; if (merge_a !== 1'b0) $display("FAIL rst_mid merge: got %b want 0", merge_a); else passed++;
        drain(to);
        checks++; if (obs_a.size() != 2 || obs_a[0] !== 9'h05A || obs_a[1] !== 9'h0C3)
            $display("FAIL rst_mid capture: got %0d entries want 2 (05a,0c3)", obs_a.size()); else passed++;
        model_flush();
    endtask

    task automatic test_full_read_coincident();
        bit to;
        int w;
        logic [8:0] nxt;
        do_reset();
        for (int i = 0; i < 4; i++) begin fr_data[i] = 8'($urandom); fr_bits[i] = 3'd0; fr_last[i] = 1'b0; end
        send_frame(4, to);
        @(negedge clk);
        data_valid = 1'b1; data = 8'h77; data_bits = 3'd0; last_bit = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        nxt = 9'h177;
        void'(exp_a.pop_front()); exp_a.push_back(nxt);
        void'(exp_c.pop_front()); exp_c.push_back(nxt);
        void'(exp_b.pop_front()); exp_b.push_back(2'b11);
        w = 0;
        while (!req_a && w < 40) begin @(negedge clk); w++; end
        @(negedge clk);
        data_valid = 1'b0;
        while (!frame_done_a && w < 80) begin @(negedge clk); w++; end
        checks++; if (w >= 80) $display("FAIL coincident timeout: got expired want frame_done"); else passed++;
        checks++; if (ovf_c !== 1'b0) $display("FAIL coincident no_drop: got %b want 0", ovf_c); else passed++;
        checks++; if (rd_data_c !== exp_c[0]) $display("FAIL coincident head: got %h want %h", rd_data_c, exp_c[0]); else passed++;
        drain(to);
        checks++; if (obs_c.size() != 4) $display("FAIL coincident count: got %0d want 4", obs_c.size()); else passed++;
        for (int k = 0; k < 4 && k < obs_c.size(); k++) begin
            checks++; if (obs_c[k] !== exp_c[k]) $display("FAIL coincident entry%0d: got %h want %h", k, obs_c[k], exp_c[k]); else passed++;
        end
        model_flush();
    endtask

    task automatic test_random();
        bit to;
        int n;
        do_reset();
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                fr_data[i] = 8'($urandom);
                fr_bits[i] = (i == 0 || $urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
                fr_last[i] = 1'($urandom);
            end
            send_frame(n, to);
            repeat (2) @(negedge clk);
            checks++; if (to) $display("FAIL random%0d timeout: got expired want frame_done", f); else passed++;
            checks++; if (bifb_a !== m_bifb) $display("FAIL random%0d bifb_a: got %0d want %0d", f, bifb_a, m_bifb); else passed++;
            checks++; if (bifb_b !== exp_bits_b(n)) $display("FAIL random%0d bifb_b: got %0d want %0d", f, bifb_b, exp_bits_b(n)); else passed++;
            checks++;
            if ({ovf_a, ovf_c, merge_a, merge_c, part_a} !== {m_ovf_a, m_ovf_c, m_merge_a, m_merge_c, m_part})
                $display("FAIL random%0d flags: got %b want %b", f, {ovf_a, ovf_c, merge_a, merge_c, part_a},
                         {m_ovf_a, m_ovf_c, m_merge_a, m_merge_c, m_part});
            else passed++;
            if ($urandom_range(0, 3) == 0) begin
                pulse_clear();
                m_ovf_a = 0; m_ovf_c = 0; m_merge_a = 0; m_merge_c = 0; m_part = 0;
            end
            if ($urandom_range(0, 2) != 0) begin
                drain(to);
                checks++;
                if (obs_a.size() != exp_a.size() || obs_c.size() != exp_c.size() || obs_b.size() != exp_b.size())
                    $display("FAIL random%0d counts: got %0d/%0d/%0d want %0d/%0d/%0d", f, obs_a.size(), obs_b.size(),
                             obs_c.size(), exp_a.size(), exp_b.size(), exp_c.size());
                else passed++;
                for (int k = 0; k < obs_a.size() && k < exp_a.size(); k++) begin
                    checks++; if (obs_a[k] !== exp_a[k]) $display("FAIL random%0d a%0d: got %h want %h", f, k, obs_a[k], exp_a[k]); else passed++;
                end
                for (int k = 0; k < obs_c.size() && k < exp_c.size(); k++) begin
                    checks++; if (obs_c[k] !== exp_c[k]) $display("FAIL random%0d c%0d: got %h want %h", f, k, obs_c[k], exp_c[k]); else passed++;
                end
                for (int k = 0; k < obs_b.size() && k < exp_b.size(); k++) begin
                    checks++; if (obs_b[k] !== exp_b[k]) $display("FAIL random%0d b%0d: got %b want %b", f, k, obs_b[k], exp_b[k]); else passed++;
                end
                model_flush();
            end
        end
    endtask

    initial begin
        rst = 1'b1; data_valid = 1'b0; data = 8'd0; data_bits = 3'd0; last_bit = 1'b0;
        rd_en = 1'b0; err_clear = 1'b0;
        model_clear();
        test_reset();
        test_full_bytes();
        test_partial_first();
        test_bit_mode();
        test_overflow_merge();
        test_reset_mid_frame();
        test_full_read_coincident();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
